seir_agent: RTL and testbench
=============================

// Module: seir_agent
// PURPOSE
//   Parametrised next-generation grid agent for the disease model: one cell of the
//   cellular automaton, N-neighbour, four-state SEIR (susceptible/exposed/infected/
//   recovered) with deterministic dwell counters and per-neighbour LFSR transmission.
//   Tiled by the grid top; out_infect[i] of one agent drives in_infect of neighbour i.
// PARAMETERS
//   NODE_ADDRESS      0             unique cell index; seeds LFSR i with NODE_ADDRESS+i+1
//   NUM_NEIGHBOURS    8             neighbour links (4 = von Neumann, 8 = Moore), >=1
//   INFECT_THRESHOLD  32'hCCCCCCCC  transmit on link i when lfsr_i <= threshold
//   EXPOSED_CYCLES    4             steps spent in EXP, >=0 (0 = SUS goes straight to INF)
//   INFECTED_CYCLES   8             steps spent in INF, >=1
//   IMMUNE_CYCLES     16            steps spent in REC; 0 = permanent immunity
// PORTS
//   clk          in   1    clock
//   rst          in   1    asynchronous active-high reset
//   step         in   1    simulation tick; state, counter, LFSRs advance only when 1
//   load_state   in   1    synchronous load of init_state, priority over step
//   init_state   in   2    0=SUS 1=EXP 2=INF 3=REC
//   in_infect    in   N    infection attempts from neighbours
//   out_infect   out  N    infection attempts to neighbours
//   curr_state   out  2    registered state
//   infect_count out  16   SUS->EXP/INF transition count (see CONFIGURATION)
// BEHAVIOUR
//   Reset (async, active-high): state=SUS, dwell counter=0, LFSR i = NODE_ADDRESS+i+1,
//     curr_state=0, out_infect=0, infect_count=0; effective immediately on rst rise.
//   LFSR: 32-bit Galois, poly x^32+x^22+x^2+x+1; one shift per step; never zero.
//   out_infect[i] = (state==INF) & (lfsr_i <= INFECT_THRESHOLD); combinational from
//     registers, so threshold 0 never transmits, 32'hFFFFFFFF always transmits.
//   Precedence per clk edge: rst > load_state > step > hold.
//   load_state: state<=init_state, counter<=0, LFSRs not shifted, regardless of step.
//   step=0 and load_state=0: all registers hold; out_infect stable.
//   FSM on step (counter width = clog2(max dwell+1)):
//     SUS: |in_infect -> EXP (or INF if EXPOSED_CYCLES==0), counter<=0; else stay.
//     EXP: counter==EXPOSED_CYCLES-1 -> INF, counter<=0; else counter++.
//     INF: counter==INFECTED_CYCLES-1 -> REC, counter<=0; else counter++.
//     REC: IMMUNE_CYCLES==0 -> stay forever; counter==IMMUNE_CYCLES-1 -> SUS,
//          counter<=0; else counter++.
//   in_infect ignored outside SUS; simultaneous multi-link hits count as one event.
//   Dwell in each timed state is exactly its *_CYCLES steps; 1-step latency from
//     the infecting step to curr_state change.
//   Loaded state starts a full dwell (counter=0).
// CONFIGURATION
//   SEIR_AGENT_STATS_EN defined: infect_count increments (saturating at 16'hFFFF) on
//     each SUS->EXP/INF transition; cleared by rst only, not by load_state.
//   Not defined: counter logic omitted, infect_count tied to 16'h0000.
// TESTING (EXPOSED=2, INFECTED=3, IMMUNE=4, N=8, step=1 unless stated)
//   1 THRESHOLD=32'hFFFFFFFF; in_infect=8'h20 for one step -> curr_state SUS,EXP,EXP,
//     INF,INF,INF,REC x4,SUS; out_infect=8'hFF exactly during the 3 INF steps.
//   2 THRESHOLD=0; load_state init_state=2 -> out_infect stays 8'h00 for 3 INF steps.
//   3 load_state=1, init_state=3, step=1, in_infect=8'hFF same edge -> state=REC, not EXP.
//   4 In INF, step=0 for 10 clks -> state, counter, out_infect unchanged; resume ->
//     remaining INF dwell completes on schedule.
//   5 rst pulsed mid-EXP between clk edges -> curr_state=0, out_infect=0 immediately.
//   6 IMMUNE_CYCLES=0, STATS_EN: three infections attempted, reload SUS between ->
//     REC held indefinitely with in_infect=8'hFF; infect_count=3.

Source files
------------

// File: rtl/seir_agent.sv
// seir_agent: one cell of the SEIR cellular automaton.
// A state machine steps the cell through SUS -> EXP -> INF -> REC -> SUS. The cell
// stays in each timed state for a fixed number of steps. While the cell is
// infected, each neighbour link has its own 32-bit Galois LFSR that decides
// whether an infection attempt goes out on that link.
// Optional feature: define SEIR_AGENT_STATS_EN to enable the saturating
// infection-event counter on infect_count_o. Without it the output is tied to 0.
module seir_agent #(
  parameter int unsigned NODE_ADDRESS     = 0,
  parameter int unsigned NUM_NEIGHBOURS   = 8,
  parameter logic [31:0] INFECT_THRESHOLD = 32'hCCCCCCCC,
  parameter int unsigned EXPOSED_CYCLES   = 4,
  parameter int unsigned INFECTED_CYCLES  = 8,
  parameter int unsigned IMMUNE_CYCLES    = 16
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      step_i,
  input  logic                      load_state_i,
  input  logic [1:0]                init_state_i,
  input  logic [NUM_NEIGHBOURS-1:0] in_infect_i,
  output logic [NUM_NEIGHBOURS-1:0] out_infect_o,
  output logic [1:0]                curr_state_o,
  output logic [15:0]               infect_count_o
);

  typedef enum logic [1:0] {
    ST_SUS = 2'd0,
    ST_EXP = 2'd1,
    ST_INF = 2'd2,
    ST_REC = 2'd3
  } state_e;

  // The dwell counter only needs to reach the longest timed dwell.
  localparam int unsigned MAX_EI    = (EXPOSED_CYCLES > INFECTED_CYCLES) ?
                                      EXPOSED_CYCLES : INFECTED_CYCLES;
  localparam int unsigned MAX_DWELL = (MAX_EI > IMMUNE_CYCLES) ? MAX_EI : IMMUNE_CYCLES;
  localparam int unsigned CNT_W     = (MAX_DWELL < 2) ? 1 : $clog2(MAX_DWELL + 1);

  // Last counter value of each dwell. A zero-length dwell exits on its first step.
  localparam int unsigned EXP_LAST = (EXPOSED_CYCLES  == 0) ? 0 : EXPOSED_CYCLES  - 1;
  localparam int unsigned INF_LAST = (INFECTED_CYCLES == 0) ? 0 : INFECTED_CYCLES - 1;
  localparam int unsigned REC_LAST = (IMMUNE_CYCLES   == 0) ? 0 : IMMUNE_CYCLES   - 1;

  // Galois taps for x^32 + x^22 + x^2 + x + 1, right-shifting form
  localparam logic [31:0] LFSR_TAPS = 32'h80200003;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             advance_c;
  logic             infect_evt_c;
  logic             exp_done_c;
  logic             inf_done_c;
  logic             rec_done_c;

  // load_state_i takes precedence over step_i, so a load never advances anything.
  assign advance_c    = step_i & ~load_state_i;
  assign infect_evt_c = (state_q == ST_SUS) & (|in_infect_i);
  assign exp_done_c   = (cnt_q == CNT_W'(EXP_LAST));
  assign inf_done_c   = (cnt_q == CNT_W'(INF_LAST));
  assign rec_done_c   = (cnt_q == CNT_W'(REC_LAST));

  // SEIR state machine with the dwell counter; a load restarts a full dwell
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_SUS;
      cnt_q   <= '0;
    end else if (load_state_i) begin
      state_q <= state_e'(init_state_i);
      cnt_q   <= '0;
    end else if (step_i) begin
      case (state_q)
        ST_SUS: begin
          if (infect_evt_c) begin
            state_q <= (EXPOSED_CYCLES == 0) ? ST_INF : ST_EXP;
            cnt_q   <= '0;
          end
        end
        ST_EXP: begin
          if (exp_done_c) begin
            state_q <= ST_INF;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        ST_INF: begin
          if (inf_done_c) begin
            state_q <= ST_REC;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        ST_REC: begin
          if (IMMUNE_CYCLES != 0) begin
            if (rec_done_c) begin
              state_q <= ST_SUS;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
        end
        default: begin
          state_q <= ST_SUS;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign curr_state_o = state_q;

  // One LFSR per neighbour link, each seeded uniquely from the cell address
  for (genvar gi = 0; gi < NUM_NEIGHBOURS; gi++) begin : g_link
    localparam logic [31:0] SEED_RAW = 32'(NODE_ADDRESS + gi + 1);
    localparam logic [31:0] SEED     = (SEED_RAW == 32'd0) ? 32'd1 : SEED_RAW;

    logic [31:0] lfsr_q;
    logic [31:0] lfsr_d;

    // Next LFSR value: shift right, fold in the taps when the bit shifted out is 1
    always_comb begin
      lfsr_d = {1'b0, lfsr_q[31:1]};
      if (lfsr_q[0]) begin
        lfsr_d = lfsr_d ^ LFSR_TAPS;
      end
    end

    // The LFSR shifts once per step and never shifts on a load
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        lfsr_q <= SEED;
      end else if (advance_c) begin
        lfsr_q <= lfsr_d;
      end
    end

    // Transmit on this link while infected and the draw is at or below the threshold
    assign out_infect_o[gi] = (state_q == ST_INF) && (lfsr_q <= INFECT_THRESHOLD);
  end

`ifdef SEIR_AGENT_STATS_EN
  logic [15:0] stat_q;

  // Count SUS exits; the counter saturates and only reset clears it
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stat_q <= 16'h0000;
    end else if (advance_c && infect_evt_c && (stat_q != 16'hFFFF)) begin
      stat_q <= stat_q + 16'd1;
    end
  end

  assign infect_count_o = stat_q;
`else
  assign infect_count_o = 16'h0000;
`endif

endmodule

// File: tb/tb_seir_agent.sv
// Bench for seir_agent. It instantiates three differently parameterised cells.
// All three cells are driven from shared inputs and checked against a model on
// every cycle. The model tracks the remaining steps in each state.
module tb_seir_agent;

  logic       clk;
  logic       rst;
  logic       step;
  logic       load;
  logic [1:0] init;
  logic [7:0] inf;

  logic [1:0]  cs0, cs1, cs2;
  logic [7:0]  oi0, oi1;
  logic [3:0]  oi2;
  logic [15:0] ic0, ic1, ic2;

  int n_checks = 0;
  int n_pass   = 0;

  // Settings of each cell: link count, threshold and dwell lengths
  int          p_n  [3] = '{8, 8, 4};
  logic [31:0] p_thr[3] = '{32'h80000000, 32'hFFFFFFFF, 32'h00000000};
  int          p_e  [3] = '{2, 2, 0};
  int          p_i  [3] = '{3, 3, 1};
  int          p_r  [3] = '{4, 4, 0};
  int          p_adr[3] = '{5, 0, 3};

  // Model state of each cell
  int          m_state[3];
  int          m_rem  [3];
  int          m_cnt  [3];
  logic [31:0] m_lfsr [3][8];

  seir_agent #(.NODE_ADDRESS(5), .NUM_NEIGHBOURS(8), .INFECT_THRESHOLD(32'h80000000),
               .EXPOSED_CYCLES(2), .INFECTED_CYCLES(3), .IMMUNE_CYCLES(4)) dut0 (
    .clk_i(clk), .rst_i(rst), .step_i(step), .load_state_i(load), .init_state_i(init),
    .in_infect_i(inf), .out_infect_o(oi0), .curr_state_o(cs0), .infect_count_o(ic0));

  seir_agent #(.NODE_ADDRESS(0), .NUM_NEIGHBOURS(8), .INFECT_THRESHOLD(32'hFFFFFFFF),
               .EXPOSED_CYCLES(2), .INFECTED_CYCLES(3), .IMMUNE_CYCLES(4)) dut1 (
    .clk_i(clk), .rst_i(rst), .step_i(step), .load_state_i(load), .init_state_i(init),
    .in_infect_i(inf), .out_infect_o(oi1), .curr_state_o(cs1), .infect_count_o(ic1));

  seir_agent #(.NODE_ADDRESS(3), .NUM_NEIGHBOURS(4), .INFECT_THRESHOLD(32'h00000000),
               .EXPOSED_CYCLES(0), .INFECTED_CYCLES(1), .IMMUNE_CYCLES(0)) dut2 (
    .clk_i(clk), .rst_i(rst), .step_i(step), .load_state_i(load), .init_state_i(init),
    .in_infect_i(inf[3:0]), .out_infect_o(oi2), .curr_state_o(cs2), .infect_count_o(ic2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish within the time limit");
    $fatal(1);
  end

  task automatic check(input string name, input int k, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s[cell %0d] at %0t: got %h expected %h", name, k, $time, act, exp);
  endtask

  function automatic logic [31:0] lfsr_next(input logic [31:0] x);
    return x[0] ? ((x >> 1) ^ 32'h80200003) : (x >> 1);
  endfunction

  function automatic int dwell(input int k, input int s);
    case (s)
      1:       return p_e[k];
      2:       return p_i[k];
      3:       return p_r[k];
      default: return 0;
    endcase
  endfunction

  function automatic logic [7:0] exp_oi(input int k);
    logic [7:0] r;
    r = 8'h00;
    for (int i = 0; i < p_n[k]; i++)
      r[i] = (m_state[k] == 2) && (m_lfsr[k][i] <= p_thr[k]);
    return r;
  endfunction

  function automatic logic [15:0] exp_ic(input int k);
`ifdef SEIR_AGENT_STATS_EN
    return (m_cnt[k] > 65535) ? 16'hFFFF : 16'(m_cnt[k]);
`else
    return (k < 0) ? 16'(m_cnt[0]) : 16'h0000;
`endif
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_state[k] = 0;
      m_rem[k]   = 0;
      m_cnt[k]   = 0;
      for (int i = 0; i < 8; i++) m_lfsr[k][i] = 32'(p_adr[k] + i + 1);
    end
  endtask

  // Apply the upcoming clock edge to the model using the current inputs
  task automatic model_clock();
    logic [7:0] mask;
    if (rst) begin
      model_reset();
      return;
    end
    for (int k = 0; k < 3; k++) begin
      if (load) begin
        m_state[k] = int'(init);
        m_rem[k]   = dwell(k, m_state[k]);
      end else if (step) begin
        for (int i = 0; i < p_n[k]; i++) m_lfsr[k][i] = lfsr_next(m_lfsr[k][i]);
        mask = 8'((1 << p_n[k]) - 1);
        case (m_state[k])
          0: if ((inf & mask) != 8'h00) begin
               m_cnt[k]++;
               m_state[k] = (p_e[k] == 0) ? 2 : 1;
               m_rem[k]   = dwell(k, m_state[k]);
             end
          1, 2: begin
               m_rem[k]--;
               if (m_rem[k] <= 0) begin
                 m_state[k] = m_state[k] + 1;
                 m_rem[k]   = dwell(k, m_state[k]);
               end
             end
          default: if (p_r[k] != 0) begin
               m_rem[k]--;
               if (m_rem[k] <= 0) m_state[k] = 0;
             end
        endcase
      end
    end
  endtask

  task automatic compare_all();
    check("curr_state",   0, 32'(cs0), 32'(m_state[0]));
    check("out_infect",   0, 32'(oi0), 32'(exp_oi(0)));
    check("infect_count", 0, 32'(ic0), 32'(exp_ic(0)));
    check("curr_state",   1, 32'(cs1), 32'(m_state[1]));
    check("out_infect",   1, 32'(oi1), 32'(exp_oi(1)));
    check("infect_count", 1, 32'(ic1), 32'(exp_ic(1)));
    check("curr_state",   2, 32'(cs2), 32'(m_state[2]));
    check("out_infect",   2, 32'(oi2), 32'(exp_oi(2)));
    check("infect_count", 2, 32'(ic2), 32'(exp_ic(2)));
  endtask

  // Hold the inputs through one active edge, then compare on the following falling edge
  task automatic drive(input logic s, input logic l, input logic [1:0] ini,
                       input logic [7:0] in_v);
    step = s; load = l; init = ini; inf = in_v;
    model_clock();
    @(negedge clk);
    compare_all();
  endtask

  // Pulse reset between clock edges and check that it takes effect immediately
  task automatic async_rst_pulse(input bit literal);
    #1 rst = 1'b1;
    #1;
    model_reset();
    compare_all();
    if (literal) begin
      check("async_rst_state", 0, 32'(cs0), 32'd0);
      check("async_rst_oi",    1, 32'(oi1), 32'd0);
    end
    #1 rst = 1'b0;
  endtask

  localparam int unsigned T1_LEN = 10;
  int t1_seq[T1_LEN] = '{1, 1, 2, 2, 2, 3, 3, 3, 3, 0};

  initial begin
    rst = 1'b1; step = 1'b0; load = 1'b0; init = 2'd0; inf = 8'h00;
    model_reset();
    @(negedge clk);
    compare_all();
    check("reset_state", 1, 32'(cs1), 32'd0);
    check("reset_oi",    1, 32'(oi1), 32'd0);
    check("reset_count", 1, 32'(ic1), 32'd0);
    rst = 1'b0;

    // Single-step infection walks the full SEIR cycle with exact dwell lengths
    drive(1'b1, 1'b0, 2'd0, 8'h20);
    check("t1_state", 1, 32'(cs1), 32'(t1_seq[0]));
    for (int s = 1; s < T1_LEN; s++) begin
      drive(1'b1, 1'b0, 2'd0, 8'h00);
      check("t1_state", 1, 32'(cs1), 32'(t1_seq[s]));
      check("t1_oi",    1, 32'(oi1), (t1_seq[s] == 2) ? 32'hFF : 32'h00);
    end

    // A zero threshold never transmits, even in INF
    drive(1'b0, 1'b1, 2'd2, 8'h00);
    check("t2_state", 2, 32'(cs2), 32'd2);
    check("t2_oi",    2, 32'(oi2), 32'd0);
    check("t2_oi_thr_max", 1, 32'(oi1), 32'hFF);

    // A load wins over step and infection on the same edge
    drive(1'b1, 1'b1, 2'd3, 8'hFF);
    check("t3_state", 0, 32'(cs0), 32'd3);
    check("t3_state", 1, 32'(cs1), 32'd3);

    // Everything holds while step is low, then the INF dwell resumes on schedule
    drive(1'b0, 1'b1, 2'd2, 8'h00);
    drive(1'b1, 1'b0, 2'd0, 8'h00);
    for (int s = 0; s < 10; s++) drive(1'b0, 1'b0, 2'd0, 8'($urandom));
    check("t4_hold_state", 1, 32'(cs1), 32'd2);
    check("t4_hold_oi",    1, 32'(oi1), 32'hFF);
    drive(1'b1, 1'b0, 2'd0, 8'h00);
    check("t4_resume", 1, 32'(cs1), 32'd2);
    drive(1'b1, 1'b0, 2'd0, 8'h00);
    check("t4_done", 1, 32'(cs1), 32'd3);

    // Reset pulsed in the middle of EXP
    drive(1'b0, 1'b1, 2'd1, 8'h00);
    drive(1'b1, 1'b0, 2'd0, 8'h00);
    async_rst_pulse(1'b1);

    // Permanent immunity: three separate infections, then REC stays under constant attack
    for (int r = 0; r < 3; r++) begin
      if (r > 0) drive(1'b0, 1'b1, 2'd0, 8'h00);
      drive(1'b1, 1'b0, 2'd0, 8'hFF);
      check("t6_infected", 2, 32'(cs2), 32'd2);
      for (int s = 0; s < 20; s++) drive(1'b1, 1'b0, 2'd0, 8'hFF);
      check("t6_rec_held", 2, 32'(cs2), 32'd3);
    end
`ifdef SEIR_AGENT_STATS_EN
    check("t6_count", 2, 32'(ic2), 32'd3);
`else
    check("t6_count", 2, 32'(ic2), 32'd0);
`endif

    // Randomised traffic with occasional loads and asynchronous resets
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 199) == 0) async_rst_pulse(1'b0);
      drive(($urandom_range(0, 3) != 0),
            ($urandom_range(0, 19) == 0),
            2'($urandom),
            ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
